// File: rtl/fifo_thresh.sv
// ---------------------------------------------------------------------------
// fifo_thresh
//
// Purpose:
//   Single-clock circular-buffer FIFO with a registered read port and
//   programmable almost-empty / almost-full thresholds. A sticky error flag
//   records any overflow (write refused because the FIFO is full) or
//   underflow (read requested while empty).
//
// Parameters:
//   DATA_WIDTH   width of one stored word
//   ADDR_WIDTH   pointer width; depth is 2**ADDR_WIDTH entries
//
// Ports:
//   clk            single clock, all state changes on the rising edge
//   reset          synchronous, active-high reset
//   wr_enable      write request for this cycle
//   data_in        write data, stored when the write is accepted
//   rd_enable      read request for this cycle
//   thr_low        almost-empty threshold (count <= thr_low)
//   thr_high       almost-full threshold  (count >= thr_high)
//   data_out       registered read data, one cycle after an accepted read
//   valid_out      high for exactly one cycle per accepted read
//   fifo_empty     count == 0
//   fifo_full      count == depth
//   almost_empty   count <= thr_low
//   almost_full    count >= thr_high
//   fifo_error     sticky overflow/underflow flag, cleared only by reset
//   occupancy      current number of stored entries
// ---------------------------------------------------------------------------
module fifo_thresh #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enable,
    input  logic [4:0]            thr_low,
    input  logic [4:0]            thr_high,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  fifo_error,
    output logic [ADDR_WIDTH:0]   occupancy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Threshold compares are done at the wider of the count width and the
    // 5-bit threshold width so that out-of-range thresholds (e.g. 17..31)
    // naturally saturate the flags instead of being truncated.
    localparam int CMP_WIDTH = ((ADDR_WIDTH + 1) > 5) ? (ADDR_WIDTH + 1) : 5;

    localparam logic [ADDR_WIDTH:0]   COUNT_ZERO = '0;
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   COUNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = COUNT_ONE[ADDR_WIDTH-1:0];

    // Storage and registered state
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wrPtr_q,    wrPtr_d;
    logic [ADDR_WIDTH-1:0] rdPtr_q,    rdPtr_d;
    logic [ADDR_WIDTH:0]   count_q,    count_d;
    logic [DATA_WIDTH-1:0] dataOut_q,  dataOut_d;
    logic                  validOut_q, validOut_d;
    logic                  error_q,    error_d;

    // Handshake decode
    logic isEmpty;
    logic isFull;
    logic rdAccept;
    logic wrAccept;
    logic overflow;
    logic underflow;

    // Widened operands for the threshold compares
    logic [CMP_WIDTH-1:0] countCmp;
    logic [CMP_WIDTH-1:0] thrLowCmp;
    logic [CMP_WIDTH-1:0] thrHighCmp;

    // Decide which requests are honoured this cycle. A read needs data to
    // be present; a write needs a free slot, or a read in the same cycle
    // that frees one, which lets a full FIFO stream at full rate. An
    // empty FIFO never accepts a read, even with a simultaneous write,
    // because the word being written is not yet readable.
    always_comb begin
        isEmpty   = (count_q == COUNT_ZERO);
        isFull    = (count_q == COUNT_FULL);
        rdAccept  = rd_enable && !isEmpty;
        wrAccept  = wr_enable && (!isFull || rdAccept);
        overflow  = wr_enable && !wrAccept;
        underflow = rd_enable && isEmpty;
    end

    // Next-state logic for pointers, count, read data and the error flag.
    // Every register holds its value unless an accepted transfer or an
    // error event says otherwise; reset is applied in the register stage.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        dataOut_d  = dataOut_q;
        validOut_d = 1'b0;
        error_d    = error_q | overflow | underflow;

        if (wrAccept) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end

        if (rdAccept) begin
            rdPtr_d    = rdPtr_q + PTR_ONE;
            dataOut_d  = mem_q[rdPtr_q];
            validOut_d = 1'b1;
        end

        // Simultaneous accepted read and write cancel out in the count
        unique case ({wrAccept, rdAccept})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control registers with synchronous reset. Reset overrides any
    // request in the same cycle and discards all stored entries by
    // rewinding the pointers and clearing the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            dataOut_q  <= '0;
            validOut_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            dataOut_q  <= dataOut_d;
            validOut_q <= validOut_d;
            error_q    <= error_d;
        end
    end

    // Storage array. It is never cleared: entries become unreachable once
    // the pointers and count are reset, so clearing would only cost logic.
    // The write is suppressed during reset so the array is left untouched.
    always_ff @(posedge clk) begin
        if (wrAccept && !reset) begin
            mem_q[wrPtr_q] <= data_in;
        end
    end

    // Status flags are pure compares of the registered count, so they
    // follow a threshold change in the same cycle.
    always_comb begin
        countCmp     = CMP_WIDTH'(count_q);
        thrLowCmp    = CMP_WIDTH'(thr_low);
        thrHighCmp   = CMP_WIDTH'(thr_high);
        fifo_empty   = isEmpty;
        fifo_full    = isFull;
        almost_empty = (countCmp <= thrLowCmp);
        almost_full  = (countCmp >= thrHighCmp);
    end

    // Output drives
    assign data_out   = dataOut_q;
    assign valid_out  = validOut_q;
    assign fifo_error = error_q;
    assign occupancy  = count_q;

endmodule

// File: tb/tb_fifo_thresh.sv
// ---------------------------------------------------------------------------
// tb_fifo_thresh
//
// Self-checking bench for fifo_thresh. The stimulus process keeps a small
// queue model of the FIFO contents; every read it expects the DUT to
// accept pushes the expected word onto a scoreboard queue, and a separate
// monitor pops and compares whenever valid_out is seen. Flags and
// occupancy are compared against the model after every cycle, with extra
// hand-computed checks at the points of interest of each scenario.
// ---------------------------------------------------------------------------
module tb_fifo_thresh;

    localparam int DW    = 6;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_enable;
    logic [DW-1:0] data_in;
    logic          rd_enable;
    logic [4:0]    thr_low;
    logic [4:0]    thr_high;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_empty;
    logic          almost_full;
    logic          fifo_error;
    logic [AW:0]   occupancy;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] modelQ[$];
    logic [DW-1:0] expQ[$];
    bit            modelErr;
    bit            lastRd;

    fifo_thresh #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_enable    (wr_enable),
        .data_in      (data_in),
        .rd_enable    (rd_enable),
        .thr_low      (thr_low),
        .thr_high     (thr_high),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .fifo_error   (fifo_error),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Monitor: every valid_out must match the oldest expected word
    always @(negedge clk) begin
        if (valid_out) begin
            if (expQ.size() == 0) begin
                checkVal("unexpected valid_out", 1, 0);
            end else begin
                checkVal("read data", int'(data_out), int'(expQ.pop_front()));
            end
        end
    end

    // Compare all status outputs against the model
    task automatic checkOutput(input string tag);
        int cnt;
        cnt = modelQ.size();
        checkVal({tag, " occupancy"},    int'(occupancy),    cnt);
        checkVal({tag, " fifo_empty"},   int'(fifo_empty),   int'(cnt == 0));
        checkVal({tag, " fifo_full"},    int'(fifo_full),    int'(cnt == DEPTH));
        checkVal({tag, " almost_empty"}, int'(almost_empty), int'(cnt <= int'(thr_low)));
        checkVal({tag, " almost_full"},  int'(almost_full),  int'(cnt >= int'(thr_high)));
        checkVal({tag, " fifo_error"},   int'(fifo_error),   int'(modelErr));
        checkVal({tag, " valid_out"},    int'(valid_out),    int'(lastRd));
    endtask

    // One clock of traffic: drive at the negedge, update the model, and
    // return at the following negedge with the inputs idled.
    task automatic applyStimulus(input bit wr, input logic [DW-1:0] din, input bit rd);
        bit rdOk;
        bit wrOk;
        wr_enable = wr;
        data_in   = din;
        rd_enable = rd;
        rdOk = rd && (modelQ.size() > 0);
        wrOk = wr && ((modelQ.size() < DEPTH) || rdOk);
        if ((wr && !wrOk) || (rd && modelQ.size() == 0)) modelErr = 1'b1;
        if (rdOk) expQ.push_back(modelQ.pop_front());
        if (wrOk) modelQ.push_back(din);
        lastRd = rdOk;
        @(posedge clk);
        @(negedge clk);
        wr_enable = 1'b0;
        rd_enable = 1'b0;
    endtask

    task automatic doReset(input bit wr, input bit rd);
        reset     = 1'b1;
        wr_enable = wr;
        rd_enable = rd;
        data_in   = 6'h11;
        modelQ.delete();
        modelErr  = 1'b0;
        lastRd    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        data_in   = '0;
        thr_low   = 5'd2;
        thr_high  = 5'd14;
        modelErr  = 1'b0;
        lastRd    = 1'b0;

        // Reset state
        doReset(1'b1, 1'b0);
        checkVal("reset occupancy",    int'(occupancy),    0);
        checkVal("reset fifo_empty",   int'(fifo_empty),   1);
        checkVal("reset fifo_full",    int'(fifo_full),    0);
        checkVal("reset almost_empty", int'(almost_empty), 1);
        checkVal("reset almost_full",  int'(almost_full),  0);
        checkVal("reset fifo_error",   int'(fifo_error),   0);
        checkVal("reset valid_out",    int'(valid_out),    0);

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b0);
            checkOutput("fill");
            if (i == 2)  checkVal("fill ae after 2nd",  int'(almost_empty), 1);
            if (i == 3)  checkVal("fill ae after 3rd",  int'(almost_empty), 0);
            if (i == 13) checkVal("fill af after 13th", int'(almost_full),  0);
            if (i == 14) checkVal("fill af after 14th", int'(almost_full),  1);
        end
        checkVal("full occupancy", int'(occupancy),  16);
        checkVal("full fifo_full", int'(fifo_full),  1);
        checkVal("full error",     int'(fifo_error), 0);

        // Overflow write is discarded
        applyStimulus(1'b1, 6'h3F, 1'b0);
        checkOutput("overflow");
        checkVal("overflow error",     int'(fifo_error), 1);
        checkVal("overflow occupancy", int'(occupancy),  16);

        // Threshold edge cases at count 16, no clock needed
        thr_high = 5'd17; #1;
        checkVal("thr_high=17 at 16", int'(almost_full), 0);
        thr_high = 5'd16; #1;
        checkVal("thr_high=16 at 16", int'(almost_full), 1);
        thr_low = 5'd16; #1;
        checkVal("thr_low=16 at 16", int'(almost_empty), 1);
        thr_low = 5'd15; #1;
        checkVal("thr_low=15 at 16", int'(almost_empty), 0);
        thr_low  = 5'd2;
        thr_high = 5'd14;
        @(negedge clk);

        // Drain 16 words, monitor checks 0x01..0x10 order
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput("drain");
        end
        checkVal("drained fifo_empty", int'(fifo_empty), 1);
        thr_high = 5'd0; #1;
        checkVal("thr_high=0 at 0", int'(almost_full), 1);
        thr_high = 5'd14;
        @(negedge clk);

        // Streaming 20 words with reads from the 2nd cycle, pointers wrap
        doReset(1'b0, 1'b0);
        for (int i = 0; i <= 20; i++) begin
            applyStimulus(i < 20, DW'(6'h20 + i), i > 0);
            checkOutput("stream");
            checkVal("stream occ<=1", int'(occupancy <= 1), 1);
        end
        checkVal("stream error", int'(fifo_error), 0);

        // Read+write on empty: write only, error set
        applyStimulus(1'b1, 6'h2A, 1'b1);
        checkOutput("empty rw");
        checkVal("empty rw occupancy", int'(occupancy),  1);
        checkVal("empty rw valid",     int'(valid_out),  0);
        checkVal("empty rw error",     int'(fifo_error), 1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("empty rw readback");

        // Read+write on full: both happen, 0x15 drains last
        doReset(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, DW'(6'h30 + i), 1'b0);
        end
        applyStimulus(1'b1, 6'h15, 1'b1);
        checkOutput("full rw");
        checkVal("full rw occupancy", int'(occupancy),  16);
        checkVal("full rw fifo_full", int'(fifo_full),  1);
        checkVal("full rw data",      int'(data_out),   6'h30);
        checkVal("full rw error",     int'(fifo_error), 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkVal("full rw last word", int'(data_out), 6'h15);
        checkOutput("full rw drained");

        // Reset mid-operation with 5 entries and an error pending
        applyStimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, DW'(6'h08 + i), 1'b0);
        end
        checkOutput("pre-reset");
        doReset(1'b1, 1'b1);
        checkVal("mid reset occupancy",  int'(occupancy),  0);
        checkVal("mid reset fifo_empty", int'(fifo_empty), 1);
        checkVal("mid reset error",      int'(fifo_error), 0);
        checkVal("mid reset valid",      int'(valid_out),  0);

        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("final idle");
        checkVal("scoreboard drained", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
